mips_cpu: RTL and testbench

//  Single-cycle 32-bit MIPS processor core: PC register, word-addressed instruction ROM, 32x32 register file, ALU and data RAM.
//  One instruction completes per clk rising edge.
//  Top of the CPU hierarchy; benches preload program memory and inspect state through fixed hierarchical names.

---
 rtl/mips_cpu.sv | 207 ++++++++++++++++++++
 tb/tb_mips_cpu.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/mips_cpu.sv
// Single-cycle 32-bit MIPS core: PC register, word-addressed instruction ROM,
// 32x32 register file, ALU/decoder and data RAM. One instruction retires per rising clk edge.

module prog_counter (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] next,
  output logic [31:0] OUT
);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) OUT <= 32'h0;
    else     OUT <= next;
  end
endmodule

// ROM contents are preloaded from outside through the InstructionMemory array;
// the load port exists so the array has a synthesizable driver and stays tied off in the core.
module instr_mem #(
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          load_en,
  input  logic [AW-1:0] load_addr,
  input  logic [31:0]   load_data,
  input  logic [AW-1:0] addr,
  output logic [31:0]   instr
);
  logic [31:0] InstructionMemory [0:DEPTH-1];

  always_ff @(posedge clk) begin
    if (load_en) InstructionMemory[load_addr] <= load_data;
  end

  assign instr = InstructionMemory[addr];
endmodule

module reg_file (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  ra1,
  input  logic [4:0]  ra2,
  output logic [31:0] rd1,
  output logic [31:0] rd2,
  input  logic        we,
  input  logic [4:0]  wa,
  input  logic [31:0] wd
);
  logic [31:0] Registers [0:31];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) Registers[i] <= 32'h0;
    end else if (we && (wa != 5'd0)) begin
      Registers[wa] <= wd;
    end
  end

  // $0 is hardwired to zero regardless of array contents
  assign rd1 = (ra1 == 5'd0) ? 32'h0 : Registers[ra1];
  assign rd2 = (ra2 == 5'd0) ? 32'h0 : Registers[ra2];
endmodule

module data_mem #(
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);
  logic [31:0] mem [0:DEPTH-1];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata = mem[addr];
endmodule

module mips_cpu #(
  parameter int IMEM_DEPTH = 256,
  parameter int DMEM_DEPTH = 256
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] pc_out
);
  localparam int IAW = $clog2(IMEM_DEPTH);
  localparam int DAW = $clog2(DMEM_DEPTH);

  logic [31:0] pc, pc_next, pc_plus4, instr;
  logic [31:0] rs_val, rt_val, simm, zimm, alu_res, mem_rdata, wd;
  logic [5:0]  op, funct;
  logic [4:0]  rs, rt, rd, shamt, rf_wa;
  logic [15:0] imm;
  logic        rf_we, mem_we, is_load;

  prog_counter ProgCounter (
    .clk  (clk),
    .rst  (rst),
    .next (pc_next),
    .OUT  (pc)
  );

  instr_mem #(.DEPTH(IMEM_DEPTH)) IM (
    .clk       (clk),
    .load_en   (1'b0),
    .load_addr ('0),
    .load_data (32'h0),
    .addr      (pc[IAW+1:2]),
    .instr     (instr)
  );

  assign op    = instr[31:26];
  assign rs    = instr[25:21];
  assign rt    = instr[20:16];
  assign rd    = instr[15:11];
  assign shamt = instr[10:6];
  assign funct = instr[5:0];
  assign imm   = instr[15:0];
  assign simm  = {{16{imm[15]}}, imm};
  assign zimm  = {16'h0, imm};

  reg_file RF (
    .clk (clk),
    .rst (rst),
    .ra1 (rs),
    .ra2 (rt),
    .rd1 (rs_val),
    .rd2 (rt_val),
    .we  (rf_we),
    .wa  (rf_wa),
    .wd  (wd)
  );

  data_mem #(.DEPTH(DMEM_DEPTH)) DM (
    .clk   (clk),
    .we    (mem_we),
    .addr  (alu_res[DAW+1:2]),
    .wdata (rt_val),
    .rdata (mem_rdata)
  );

  assign pc_plus4 = pc + 32'd4;

  // Decode and execute; anything not matched below falls through as a NOP
  always_comb begin
    alu_res = 32'h0;
    rf_we   = 1'b0;
    rf_wa   = rd;
    mem_we  = 1'b0;
    is_load = 1'b0;
    pc_next = pc_plus4;
    case (op)
      6'h00: begin
        rf_we = 1'b1;
        case (funct)
          6'h20, 6'h21: alu_res = rs_val + rt_val;
          6'h22, 6'h23: alu_res = rs_val - rt_val;
          6'h24: alu_res = rs_val & rt_val;
          6'h25: alu_res = rs_val | rt_val;
          6'h26: alu_res = rs_val ^ rt_val;
          6'h27: alu_res = ~(rs_val | rt_val);
          6'h2A: alu_res = {31'h0, $signed(rs_val) < $signed(rt_val)};
          6'h2B: alu_res = {31'h0, rs_val < rt_val};
          6'h00: alu_res = rt_val << shamt;
          6'h02: alu_res = rt_val >> shamt;
          6'h03: alu_res = $unsigned($signed(rt_val) >>> shamt);
          6'h08: begin
            rf_we   = 1'b0;
            pc_next = rs_val;
          end
          default: rf_we = 1'b0;
        endcase
      end
      6'h08, 6'h09: begin alu_res = rs_val + simm; rf_we = 1'b1; rf_wa = rt; end
      6'h0A: begin alu_res = {31'h0, $signed(rs_val) < $signed(simm)}; rf_we = 1'b1; rf_wa = rt; end
      6'h0C: begin alu_res = rs_val & zimm; rf_we = 1'b1; rf_wa = rt; end
      6'h0D: begin alu_res = rs_val | zimm; rf_we = 1'b1; rf_wa = rt; end
      6'h0E: begin alu_res = rs_val ^ zimm; rf_we = 1'b1; rf_wa = rt; end
      6'h0F: begin alu_res = {imm, 16'h0}; rf_we = 1'b1; rf_wa = rt; end
      6'h23: begin
        alu_res = rs_val + simm;
        is_load = 1'b1;
        rf_we   = 1'b1;
        rf_wa   = rt;
      end
      6'h2B: begin alu_res = rs_val + simm; mem_we = 1'b1; end
      6'h04: if (rs_val == rt_val) pc_next = pc_plus4 + {simm[29:0], 2'b00};
      6'h05: if (rs_val != rt_val) pc_next = pc_plus4 + {simm[29:0], 2'b00};
      6'h02: pc_next = {pc_plus4[31:28], instr[25:0], 2'b00};
      6'h03: begin
        pc_next = {pc_plus4[31:28], instr[25:0], 2'b00};
        alu_res = pc_plus4;
        rf_we   = 1'b1;
        rf_wa   = 5'd31;
      end
      default: ;
    endcase
  end

  assign wd     = is_load ? mem_rdata : alu_res;
  assign pc_out = pc;
endmodule

// File: tb/tb_mips_cpu.sv
// Directed-program bench for mips_cpu: loads short programs into the ROM during reset,
// steps the clock and compares PC / register contents against hand-computed values.

module tb_mips_cpu;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] pc_out;

  int tests = 0;
  int fails = 0;

  mips_cpu dut (
    .clk    (clk),
    .rst    (rst),
    .pc_out (pc_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] reg_val(input int idx);
    return dut.RF.Registers[idx];
  endfunction

  task automatic clear_rom();
    for (int i = 0; i < 256; i++) dut.IM.InstructionMemory[i] = 32'h0;
  endtask

  task automatic put(input int idx, input logic [31:0] w);
    dut.IM.InstructionMemory[idx] = w;
  endtask

  task automatic release_rst();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    // ALU program, then reset applied mid-run
    rst = 1'b1;
    clear_rom();
    put(0, 32'h20080005);   // addi $t0,$0,5
    put(1, 32'h01084820);   // add  $t1,$t0,$t0
    #2;
    check("reset_pc", pc_out, 32'h0);
    check("reset_t0", reg_val(8), 32'h0);
    release_rst();
    step(2);
    check("alu_t0", reg_val(8), 32'h5);
    check("alu_t1", reg_val(9), 32'hA);
    check("alu_pc", pc_out, 32'h8);
    step(3);
    check("nop_run_pc", pc_out, 32'h14);
    rst = 1'b1;
    #1;
    check("async_rst_pc", pc_out, 32'h0);
    for (int r = 8; r < 32; r++) check($sformatf("async_rst_r%0d", r), reg_val(r), 32'h0);
    release_rst();
    step(1);
    check("restart_pc", pc_out, 32'h4);
    check("restart_t0", reg_val(8), 32'h5);

    // Store then load through data memory
    rst = 1'b1;
    put(2, 32'hAC090004);   // sw $t1,4($0)
    put(3, 32'h8C0A0004);   // lw $t2,4($0)
    release_rst();
    step(4);
    check("mem_t2", reg_val(10), 32'hA);
    check("mem_pc", pc_out, 32'h10);

    // Branches, $0 write discard, immediates and shifts
    rst = 1'b1;
    clear_rom();
    put(0, 32'h10000001);   // beq $0,$0,+1
    put(1, 32'h20080007);   // addi $t0,$0,7 (skipped)
    put(2, 32'h200000FF);   // addi $0,$0,0xFF
    put(3, 32'h14000001);   // bne $0,$0,+1 (not taken)
    put(4, 32'h2008FFFF);   // addi $t0,$0,-1
    put(5, 32'h3109FFFF);   // andi $t1,$t0,0xFFFF
    put(6, 32'h3C0A1234);   // lui  $t2,0x1234
    put(7, 32'h00085903);   // sra  $t3,$t0,4
    put(8, 32'h00086702);   // srl  $t4,$t0,28
    put(9, 32'h0100682A);   // slt  $t5,$t0,$0
    put(10, 32'h0100702B);  // sltu $t6,$t0,$0
    release_rst();
    step(1);
    check("beq_taken_pc", pc_out, 32'h8);
    step(1);
    check("zero_reg", reg_val(0), 32'h0);
    check("skipped_t0", reg_val(8), 32'h0);
    step(1);
    check("bne_not_taken_pc", pc_out, 32'h10);
    step(7);
    check("addi_sext", reg_val(8), 32'hFFFFFFFF);
    check("andi_zext", reg_val(9), 32'h0000FFFF);
    check("lui", reg_val(10), 32'h12340000);
    check("sra", reg_val(11), 32'hFFFFFFFF);
    check("srl", reg_val(12), 32'h0000000F);
    check("slt_signed", reg_val(13), 32'h1);
    check("sltu_unsigned", reg_val(14), 32'h0);

    // jal / jr
    rst = 1'b1;
    clear_rom();
    put(0, 32'h0C000004);   // jal 0x10
    put(4, 32'h03E00008);   // jr $ra
    release_rst();
    step(1);
    check("jal_ra", reg_val(31), 32'h4);
    check("jal_pc", pc_out, 32'h10);
    step(1);
    check("jr_pc", pc_out, 32'h4);
    step(1);
    check("after_jr_pc", pc_out, 32'h8);

    // Running off the program wraps the ROM index back to word 0
    rst = 1'b1;
    clear_rom();
    put(0, 32'h21080001);   // addi $t0,$t0,1
    release_rst();
    step(257);
    check("wrap_pc", pc_out, 32'h404);
    check("wrap_t0", reg_val(8), 32'h2);

    // IsPowerOf2: $v0 = (a0 & (a0-1)) == 0
    for (int k = 0; k < 2; k++) begin
      rst = 1'b1;
      clear_rom();
      put(0, (k == 0) ? 32'h20040008 : 32'h20040006);  // addi $a0,$0,x
      put(1, 32'h2088FFFF);   // addi $t0,$a0,-1
      put(2, 32'h00884824);   // and  $t1,$a0,$t0
      put(3, 32'h20020000);   // addi $v0,$0,0
      put(4, 32'h15200001);   // bne  $t1,$0,+1
      put(5, 32'h20020001);   // addi $v0,$0,1
      put(6, 32'h08000006);   // j    self
      release_rst();
      step(492);
      check($sformatf("pow2_v0_%0d", k), reg_val(2), (k == 0) ? 32'h1 : 32'h0);
      check($sformatf("pow2_pc_%0d", k), pc_out, 32'h18);
      $display("[TB] dump a0=%0d pc=%08h", (k == 0) ? 8 : 6, pc_out);
      for (int r = 0; r < 32; r++) $display("[TB]   r%0d = %08h", r, reg_val(r));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
